// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the four-tap FIR MAC engine
// Purpose: controller state encoding and datapath widths used by
//          fir_mac_engine and fir_mac_datapath.
// Contents: NUM_TAPS, DATA_W, ACC_W, Q_SHIFT, fir_state_e.
package fir_pkg;

  localparam int NUM_TAPS = 4;
  localparam int DATA_W   = 16;
  localparam int ACC_W    = 34;
  localparam int Q_SHIFT  = 15;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_ACK   = 4'd2,
    ST_SHIFT = 4'd3,
    ST_MAC0  = 4'd4,
    ST_MAC1  = 4'd5,
    ST_MAC2  = 4'd6,
    ST_MAC3  = 4'd7,
    ST_DONE  = 4'd8
  } fir_state_e;

endpackage

// File: rtl/fir_mac_datapath.sv
// rtl/fir_mac_datapath.sv - sample history, coefficient copy, accumulator and result
// Purpose: storage and arithmetic for the FIR engine, sequenced by the
//          controller state it is handed.
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   state_i        current controller state
//   tap_i          coefficient index being loaded (valid in ST_LOAD)
//   sample_data_i  sample shifted into the history in ST_SHIFT
//   coef_i         coefficient captured into c[tap_i] in ST_LOAD
//   fir_out_o      filtered result, updated in ST_DONE
//   err_o          overflow flag of the last result, updated in ST_DONE
// Build option: FIR_SATURATE_EN clamps an overflowed result to all-ones;
//               otherwise the result wraps (truncates).
module fir_mac_datapath
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  fir_state_e        state_i,
  input  logic [1:0]        tap_i,
  input  logic [DATA_W-1:0] sample_data_i,
  input  logic [DATA_W-1:0] coef_i,
  output logic [DATA_W-1:0] fir_out_o,
  output logic              err_o
);

  logic [DATA_W-1:0]   hist_q [NUM_TAPS];
  logic [DATA_W-1:0]   coef_q [NUM_TAPS];
  logic [ACC_W-1:0]    acc_q;
  logic [1:0]          mac_idx;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_sum;
  logic                ovf;
  logic [DATA_W-1:0]   result;

  // Each MAC state consumes one tap; c[0] pairs with the newest sample h[0].
  always_comb begin
    mac_idx = 2'd0;
    case (state_i)
      ST_MAC1: mac_idx = 2'd1;
      ST_MAC2: mac_idx = 2'd2;
      ST_MAC3: mac_idx = 2'd3;
      default: mac_idx = 2'd0;
    endcase
  end

  assign prod    = (2*DATA_W)'(hist_q[mac_idx]) * (2*DATA_W)'(coef_q[mac_idx]);
  assign acc_sum = acc_q + ACC_W'(prod);

  // Q1.15 coefficients: the 16-bit result is acc[30:15]; any bit above it
  // means the true value does not fit.
  assign ovf = |acc_q[ACC_W-1:Q_SHIFT+DATA_W];

`ifdef FIR_SATURATE_EN
  assign result = ovf ? {DATA_W{1'b1}} : acc_q[Q_SHIFT+DATA_W-1:Q_SHIFT];
`else
  assign result = acc_q[Q_SHIFT+DATA_W-1:Q_SHIFT];
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      acc_q     <= '0;
      fir_out_o <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state_i)
        ST_LOAD: coef_q[tap_i] <= coef_i;
        ST_SHIFT: begin
          for (int i = NUM_TAPS - 1; i > 0; i--) begin
            hist_q[i] <= hist_q[i-1];
          end
          hist_q[0] <= sample_data_i;
          acc_q     <= '0;
        end
        ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3: acc_q <= acc_sum;
        ST_DONE: begin
          fir_out_o <= result;
          err_o     <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - four-tap sequential FIR compute engine (top)
// Purpose: controller FSM and tap counter; reloads a coherent coefficient
//          copy on request and runs one 4-cycle MAC per accepted sample.
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   sample_data          sample from the register slave
//   data_ready           level, a new sample is pending
//   new_coefficient_set  level, coefficient bank changed and must be reloaded
//   fir_coefficient      coefficient selected by coefficient_num
//   coefficient_num      coefficient index being fetched (0 outside reload)
//   clear_new_coeff      one-cycle reload acknowledge
//   modwait              engine busy
//   fir_out              filtered result, held until the next one
//   err                  overflow flag of the last result
// Build option: FIR_SATURATE_EN selects saturating output (see datapath).
module fir_mac_engine #(
  parameter int NUM_TAPS = 4,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              data_ready,
  input  logic              new_coefficient_set,
  input  logic [DATA_W-1:0] fir_coefficient,
  output logic [1:0]        coefficient_num,
  output logic              clear_new_coeff,
  output logic              modwait,
  output logic [DATA_W-1:0] fir_out,
  output logic              err
);

  localparam logic [1:0] LAST_TAP = 2'(NUM_TAPS - 1);

  fir_pkg::fir_state_e state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                modwait_q;
  logic                clear_q;

  // A pending reload wins over a pending sample so the sample is always
  // filtered with the newest coefficient set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      fir_pkg::ST_IDLE: begin
        if (new_coefficient_set) begin
          state_d = fir_pkg::ST_LOAD;
          cnt_d   = 2'd0;
        end else if (data_ready) begin
          state_d = fir_pkg::ST_SHIFT;
        end
      end
      fir_pkg::ST_LOAD: begin
        if (cnt_q == LAST_TAP) state_d = fir_pkg::ST_ACK;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      fir_pkg::ST_ACK:   state_d = fir_pkg::ST_IDLE;
      fir_pkg::ST_SHIFT: state_d = fir_pkg::ST_MAC0;
      fir_pkg::ST_MAC0:  state_d = fir_pkg::ST_MAC1;
      fir_pkg::ST_MAC1:  state_d = fir_pkg::ST_MAC2;
      fir_pkg::ST_MAC2:  state_d = fir_pkg::ST_MAC3;
      fir_pkg::ST_MAC3:  state_d = fir_pkg::ST_DONE;
      fir_pkg::ST_DONE:  state_d = fir_pkg::ST_IDLE;
      default:           state_d = fir_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= fir_pkg::ST_IDLE;
      cnt_q     <= 2'd0;
      modwait_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      modwait_q <= (state_d != fir_pkg::ST_IDLE);
      clear_q   <= (state_d == fir_pkg::ST_ACK);
    end
  end

  assign coefficient_num = (state_q == fir_pkg::ST_LOAD) ? cnt_q : 2'd0;
  assign clear_new_coeff = clear_q;
  assign modwait         = modwait_q;

  fir_mac_datapath u_datapath (
    .clk           (clk),
    .n_rst         (n_rst),
    .state_i       (state_q),
    .tap_i         (cnt_q),
    .sample_data_i (sample_data),
    .coef_i        (fir_coefficient),
    .fir_out_o     (fir_out),
    .err_o         (err)
  );

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - self-checking bench for fir_mac_engine
module tb_fir_mac_engine;

  logic        clk;
  logic        n_rst;
  logic [15:0] sample_data;
  logic        data_ready;
  logic        new_coefficient_set;
  logic [15:0] fir_coefficient;
  logic [1:0]  coefficient_num;
  logic        clear_new_coeff;
  logic        modwait;
  logic [15:0] fir_out;
  logic        err;

  // Slave-side coefficient bank, read combinationally by index.
  logic [15:0] bank [4];
  logic [15:0] pend [4];
  assign fir_coefficient = bank[coefficient_num];

  fir_mac_engine dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .sample_data         (sample_data),
    .data_ready          (data_ready),
    .new_coefficient_set (new_coefficient_set),
    .fir_coefficient     (fir_coefficient),
    .coefficient_num     (coefficient_num),
    .clear_new_coeff     (clear_new_coeff),
    .modwait             (modwait),
    .fir_out             (fir_out),
    .err                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  bit chk_en;
  bit in_load;
  bit ack_exp;

  // Reference model: coefficient copy, sample history, last result.
  longint unsigned m_hist [4];
  longint unsigned m_coef [4];
  logic [15:0]     exp_fir;
  logic            exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = 0;
      m_coef[i] = 0;
    end
    exp_fir = 16'd0;
    exp_err = 1'b0;
  endtask

  // y = sum(h[i]*c[i]) / 2^15 with c[0] on the newest sample.
  task automatic model_sample(input logic [15:0] s);
    longint unsigned acc;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = longint'(s);
    acc = 0;
    for (int i = 0; i < 4; i++) acc += m_hist[i] * m_coef[i];
    exp_err = (acc >= 64'h8000_0000);
`ifdef FIR_SATURATE_EN
    exp_fir = exp_err ? 16'hFFFF : 16'((acc / 32768) % 65536);
`else
    exp_fir = 16'((acc / 32768) % 65536);
`endif
  endtask

  // Every cycle the result outputs must equal the last modelled result.
  always @(negedge clk) begin
    if (chk_en) begin
      check("fir_out_hold", 32'(fir_out), 32'(exp_fir));
      check("err_hold", 32'(err), 32'(exp_err));
      check("clear_new_coeff", 32'(clear_new_coeff), 32'(ack_exp));
      if (!in_load) check("coefficient_num_idle", 32'(coefficient_num), 32'd0);
    end
  end

  task automatic do_reset();
    chk_en              = 1'b0;
    data_ready          = 1'b0;
    new_coefficient_set = 1'b0;
    sample_data         = 16'd0;
    n_rst               = 1'b1;
    #1;
    n_rst = 1'b0;
    #1;
    check("rst_fir_out", 32'(fir_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_modwait", 32'(modwait), 32'd0);
    check("rst_clear", 32'(clear_new_coeff), 32'd0);
    check("rst_cnum", 32'(coefficient_num), 32'd0);
    tick();
    tick();
    n_rst = 1'b1;
    model_reset();
    in_load = 1'b0;
    ack_exp = 1'b0;
    chk_en  = 1'b1;
  endtask

  task automatic do_reload(input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3);
    bank[0] = b0; bank[1] = b1; bank[2] = b2; bank[3] = b3;
    new_coefficient_set = 1'b1;
    in_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("load_cnum", 32'(coefficient_num), 32'(i));
      check("load_modwait", 32'(modwait), 32'd1);
    end
    tick();
    in_load = 1'b0;
    ack_exp = 1'b1;
    check("ack_pulse", 32'(clear_new_coeff), 32'd1);
    check("ack_modwait", 32'(modwait), 32'd1);
    new_coefficient_set = 1'b0;
    tick();
    ack_exp = 1'b0;
    check("reload_done_modwait", 32'(modwait), 32'd0);
    m_coef[0] = b0; m_coef[1] = b1; m_coef[2] = b2; m_coef[3] = b3;
  endtask

  // Accept one sample; optionally raise a reload request (with bank <- pend)
  // while the MAC is in its second tap.
  task automatic do_sample(input logic [15:0] s, input bit mid_ncs);
    sample_data = s;
    data_ready  = 1'b1;
    tick();
    check("accept_modwait", 32'(modwait), 32'd1);
    data_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("busy_modwait", 32'(modwait), 32'd1);
      if (mid_ncs && i == 2) begin
        for (int t = 0; t < 4; t++) bank[t] = pend[t];
        new_coefficient_set = 1'b1;
      end
    end
    tick();
    model_sample(s);
    check("done_modwait", 32'(modwait), 32'd0);
    check("done_fir_out", 32'(fir_out), 32'(exp_fir));
    check("done_err", 32'(err), 32'(exp_err));
  endtask

  task automatic expect_lit(input string name, input logic [15:0] f, input logic e);
    check({name, "_fir"}, 32'(fir_out), 32'(f));
    check({name, "_err"}, 32'(err), 32'(e));
  endtask

  logic [15:0] rc [4];
  bit          mid;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    in_load = 1'b0;
    ack_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bank[i] = 16'd0;
      pend[i] = 16'd0;
    end
    sample_data         = 16'd0;
    data_ready          = 1'b0;
    new_coefficient_set = 1'b0;
    n_rst               = 1'b1;
    model_reset();

    do_reset();
    do_sample(16'd100, 1'b0);
    expect_lit("zero_coef", 16'd0, 1'b0);

    do_reload(16'h8000, 16'h0000, 16'h0000, 16'h0000);
    do_sample(16'd100, 1'b0);
    expect_lit("unity_c0", 16'd100, 1'b0);

    // Reset in the middle of a MAC.
    sample_data = 16'd100;
    data_ready  = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
    tick();
    tick();
    do_reset();
    do_sample(16'd100, 1'b0);
    expect_lit("post_reset", 16'd0, 1'b0);

    do_reset();
    do_reload(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      do_sample(16'd100, 1'b0);
      expect_lit("accum", 16'(100 * (i + 1)), 1'b0);
    end

    do_reset();
    do_reload(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    do_sample(16'hFFFF, 1'b0);
    expect_lit("single_max", 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) do_sample(16'hFFFF, 1'b0);
`ifdef FIR_SATURATE_EN
    expect_lit("overflow", 16'hFFFF, 1'b1);
`else
    expect_lit("overflow", 16'hFFFC, 1'b1);
`endif

    // Reload and sample requested together: reload first.
    do_reset();
    sample_data = 16'd200;
    data_ready  = 1'b1;
    do_reload(16'h4000, 16'h0000, 16'h0000, 16'h0000);
    do_sample(16'd200, 1'b0);
    expect_lit("priority", 16'd100, 1'b0);

    // Reload request during MAC1 must not disturb the running result.
    pend[0] = 16'h8000; pend[1] = 16'h8000; pend[2] = 16'h0000; pend[3] = 16'h0000;
    do_sample(16'd300, 1'b1);
    expect_lit("coherent_old", 16'd150, 1'b0);
    do_reload(pend[0], pend[1], pend[2], pend[3]);
    do_sample(16'd50, 1'b0);
    expect_lit("coherent_new", 16'd350, 1'b0);

    // Randomized traffic against the model.
    for (int r = 0; r < 4; r++) begin
      for (int t = 0; t < 4; t++) rc[t] = 16'($urandom_range(0, 65535));
      do_reload(rc[0], rc[1], rc[2], rc[3]);
      for (int s = 0; s < 6; s++) begin
        mid = ($urandom_range(0, 3) == 0);
        if (mid) for (int t = 0; t < 4; t++) pend[t] = 16'($urandom_range(0, 40000));
        do_sample(16'($urandom_range(0, 65535)), mid);
        if (mid) do_reload(pend[0], pend[1], pend[2], pend[3]);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
# fir_mac_engine

- Four-tap FIR compute engine; sits directly downstream of the AHB-Lite slave register interface.
- Consumes `sample_data`/`data_ready` and the coefficient bank (via `coefficient_num` → `fir_coefficient`) and returns `fir_out`, `err`, `modwait` and `clear_new_coeff`.
- Keeps a local, coherent copy of the four coefficients and a 4-deep sample history.
- Computes one filtered output per accepted sample with a multi-cycle sequential MAC.

## Interface
Parameters:
- NUM_TAPS, 4, number of taps/history depth (fixed at 4 by the register map)
- DATA_W, 16, sample/coefficient/output width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- sample_data  in  16  unsigned sample from slave
- data_ready  in  1  level: new sample pending (slave drops it once modwait seen)
- new_coefficient_set  in  1  level: coefficient bank updated, reload required
- fir_coefficient  in  16  coefficient selected by coefficient_num (combinational in slave)
- coefficient_num  out  2  coefficient index being fetched
- clear_new_coeff  out  1  one-cycle pulse acknowledging reload
- modwait  out  1  engine busy
- fir_out  out  16  filtered result, held until next DONE
- err  out  1  overflow flag of last result

## Operation
- Reset: all outputs 0; history, local coefficients, accumulator 0; state IDLE.
- States: IDLE, LOAD, ACK, SHIFT, MAC0..MAC3, DONE.
- IDLE priority: new_coefficient_set=1 → LOAD (even if data_ready=1); else data_ready=1 → SHIFT; else stay.
- LOAD:
  - 4 cycles; tap counter 0..3 drives coefficient_num.
  - Each cycle captures fir_coefficient into c[counter].
  - After counter 3 → ACK.
- ACK: clear_new_coeff=1 for exactly this cycle → IDLE.
- SHIFT: history h3←h2, h2←h1, h1←h0, h0←sample_data; accumulator cleared → MAC0.
- MACn: acc += h[n]*c[n] (16×16 unsigned → 32-bit product, 34-bit accumulator); c0 (reg addr 6/7) applies to newest sample.
- DONE:
  - Coefficients are Q1.15 (0x8000 = 1.0).
  - Overflow = acc[33:31] != 0.
  - err ← overflow; fir_out ← result per Configuration → IDLE.
- err holds until the next DONE.
- coefficient_num = 0 outside LOAD.

## Timing
- modwait is registered: modwait ← (next_state != IDLE).
- Sample accepted at edge k:
  - modwait=1 after k.
  - SHIFT exits at k+1; MAC0..MAC3 exit at k+2..k+5; DONE exits at k+6.
  - fir_out/err valid and modwait=0 after edge k+6. Latency 6 cycles, throughput one sample per 7 cycles minimum.
- Reload entered at edge j:
  - coefficient_num=0..3 during cycles after j..j+3.
  - clear_new_coeff high after j+4.
  - IDLE, modwait=0 after j+5.
  - The slave clears new_coefficient_set on the edge after clear_new_coeff, so there is no double reload.
- Sample write during modwait=1 is discarded by the slave (data_ready forced low). The engine requires no handling for this.
- new_coefficient_set rising mid-sample is ignored until IDLE. The current computation uses the old coherent coefficient set.
- Async reset mid-operation aborts immediately. All state returns to reset values; no clear_new_coeff is emitted.

## Configuration
- FIR_SATURATE_EN defined: on overflow fir_out = 16'hFFFF; otherwise acc[30:15].
- Not defined: fir_out = acc[30:15] always (truncating wrap).
- err is asserted on overflow in both builds.

## Structure
- Shared package fir_pkg:
  - state enum type
  - NUM_TAPS
  - DATA_W
  - ACC_W=34
  - Q_SHIFT=15
- Sub-module fir_mac_datapath: history shift register, coefficient registers, 34-bit accumulator, overflow/result logic.
- Controller FSM plus tap counter stay in fir_mac_engine.

## Test plan
- Reset: assert n_rst=0 mid-MAC → all outputs 0 immediately; after release, one sample of 100 with zero coefficients gives fir_out=0.
- Reload: new_coefficient_set=1, bank {0x8000,0,0,0} → coefficient_num 0,1,2,3, one clear_new_coeff pulse, modwait low 5 cycles after entry; then sample 100 → fir_out=100, err=0, 6 cycles after acceptance.
- Accumulation: all coefficients 0x8000, four samples of 100 → fir_out 100, 200, 300, 400.
- Overflow: all coefficients 0x8000, four samples 0xFFFF:
  - 4th result err=1.
  - fir_out=0xFFFF with FIR_SATURATE_EN, 0xFFFC without.
  - Single 0xFFFF gives 0xFFFF, err=0.
- Priority/coherence:
  - data_ready and new_coefficient_set both high in IDLE → reload runs first, then sample processed with new coefficients.
  - new_coefficient_set raised during MAC1 → current result uses old coefficients.
